axi_lite_init_seq: RTL and testbench

AXI_LITE_INIT_SEQ -- requirements
Module: axi_lite_init_seq

---
 rtl/axi_lite_init_seq.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_init_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_init_seq.sv
// axi_lite_init_seq: replays a small register script (WRITE, READ_CHECK, POLL, END)
// over an AXI-Lite master port. The script table is loaded through Cfg_* while
// idle. Each handshake is guarded by a watchdog, and the first failure latches
// an error code together with the failing entry index.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for Start after reset
// S_FETCH   | decode table entry idx
// S_WR      | aw/w channels presented, waiting for both handshakes
// S_WR_RESP | bready high, waiting for the write response
// S_RD      | arvalid high, waiting for arready
// S_RD_DATA | rready high, waiting for read data
// S_CHECK   | masked compare of captured read data
// S_DONE    | script finished cleanly, CPU_init_end held
// S_ERROR   | script aborted, Init_err/Err_code/Err_idx held
module axi_lite_init_seq #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 16,
   parameter int POLL_MAX = 64,
   parameter int TIMEOUT  = 255,
   localparam int IW      = $clog2(DEPTH)
) (
   input  logic              Clk_reg,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Cfg_we,
   input  logic [IW-1:0]     Cfg_idx,
   input  logic [1:0]        Cfg_op,
   input  logic [ADDR_W-1:0] Cfg_addr,
   input  logic [DATA_W-1:0] Cfg_data,
   input  logic [DATA_W-1:0] Cfg_mask,
   output logic [ADDR_W-1:0] S_AXI_awaddr,
   output logic              S_AXI_awvalid,
   output logic [DATA_W-1:0] S_AXI_wdata,
   output logic              S_AXI_wvalid,
   output logic              S_AXI_bready,
   output logic [ADDR_W-1:0] S_AXI_araddr,
   output logic              S_AXI_arvalid,
   output logic              S_AXI_rready,
   input  logic              S_AXI_awready,
   input  logic              S_AXI_wready,
   input  logic              S_AXI_bvalid,
   input  logic [1:0]        S_AXI_bresp,
   input  logic              S_AXI_arready,
   input  logic              S_AXI_rvalid,
   input  logic [DATA_W-1:0] S_AXI_rdata,
   input  logic [1:0]        S_AXI_rresp,
   output logic              Busy,
   output logic              CPU_init_end,
   output logic              Init_err,
   output logic [1:0]        Err_code,
   output logic [IW-1:0]     Err_idx
);

   localparam logic [1:0] OP_END   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_POLL  = 2'b11;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_RESP = 2'b01;
   localparam logic [1:0] ERR_DATA = 2'b10;
   localparam logic [1:0] ERR_TO   = 2'b11;

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int PW = $clog2(POLL_MAX + 1);
   localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT - 1);
   localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);
   localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t            state;
   logic [IW-1:0]     idx;
   logic [PW-1:0]     poll_cnt;
   logic [WW-1:0]     wd_cnt;
   logic              aw_done;
   logic              w_done;
   logic [DATA_W-1:0] rdata_q;

   logic [1:0]        tbl_op   [DEPTH];
   logic [ADDR_W-1:0] tbl_addr [DEPTH];
   logic [DATA_W-1:0] tbl_data [DEPTH];
   logic [DATA_W-1:0] tbl_mask [DEPTH];

   logic              aw_ok;
   logic              w_ok;
   logic              wd_tc;
   logic              match;
   logic [PW-1:0]     poll_nxt;
   logic              err_req;
   logic [1:0]        err_code_nxt;
   logic              adv;

   // Script opcodes reset to END so an unloaded table finishes immediately.
   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) tbl_op[i] <= OP_END;
      end else if (Cfg_we && !Busy) begin
         tbl_op[Cfg_idx] <= Cfg_op;
      end
   end

   // Entry payload needs no reset: it is only used once its opcode has been written.
   always_ff @(posedge Clk_reg) begin
      if (Cfg_we && !Busy) begin
         tbl_addr[Cfg_idx] <= Cfg_addr;
         tbl_data[Cfg_idx] <= Cfg_data;
         tbl_mask[Cfg_idx] <= Cfg_mask;
      end
   end

   // The table cannot change while busy, so the current entry is read directly.
   assign aw_ok    = aw_done | (S_AXI_awvalid & S_AXI_awready);
   assign w_ok     = w_done  | (S_AXI_wvalid  & S_AXI_wready);
   assign wd_tc    = (wd_cnt == '0);
   assign match    = ((rdata_q ^ tbl_data[idx]) & tbl_mask[idx]) == '0;
   assign poll_nxt = poll_cnt + PW'(1);

   // Decide per cycle whether the current entry completes or the script aborts.
   always_comb begin
      err_req      = 1'b0;
      err_code_nxt = ERR_NONE;
      adv          = 1'b0;
      case (state)
         S_WR: begin
            if (!(aw_ok && w_ok) && wd_tc) begin
               err_req      = 1'b1;
               err_code_nxt = ERR_TO;
            end
         end
         S_WR_RESP: begin
            if (S_AXI_bvalid) begin
               if (S_AXI_bresp != 2'b00) begin
                  err_req      = 1'b1;
                  err_code_nxt = ERR_RESP;
               end else begin
                  adv = 1'b1;
               end
            end else if (wd_tc) begin
               err_req      = 1'b1;
               err_code_nxt = ERR_TO;
            end
         end
         S_RD: begin
            if (!S_AXI_arready && wd_tc) begin
               err_req      = 1'b1;
               err_code_nxt = ERR_TO;
            end
         end
         S_RD_DATA: begin
            if (S_AXI_rvalid) begin
               if (S_AXI_rresp != 2'b00) begin
                  err_req      = 1'b1;
                  err_code_nxt = ERR_RESP;
               end
            end else if (wd_tc) begin
               err_req      = 1'b1;
               err_code_nxt = ERR_TO;
            end
         end
         S_CHECK: begin
            if (match) begin
               adv = 1'b1;
            end else if (tbl_op[idx] != OP_POLL || poll_nxt == POLL_LIM) begin
               err_req      = 1'b1;
               err_code_nxt = ERR_DATA;
            end
         end
         default: ;
      endcase
   end

   // Sequencer: normal channel progress in the case, then advance/abort override it.
   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) begin
         state         <= S_IDLE;
         idx           <= '0;
         poll_cnt      <= '0;
         wd_cnt        <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         rdata_q       <= '0;
         S_AXI_awaddr  <= '0;
         S_AXI_awvalid <= 1'b0;
         S_AXI_wdata   <= '0;
         S_AXI_wvalid  <= 1'b0;
         S_AXI_bready  <= 1'b0;
         S_AXI_araddr  <= '0;
         S_AXI_arvalid <= 1'b0;
         S_AXI_rready  <= 1'b0;
         Busy          <= 1'b0;
         CPU_init_end  <= 1'b0;
         Init_err      <= 1'b0;
         Err_code      <= ERR_NONE;
         Err_idx       <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (Start) begin
                  state        <= S_FETCH;
                  idx          <= '0;
                  poll_cnt     <= '0;
                  Busy         <= 1'b1;
                  CPU_init_end <= 1'b0;
                  Init_err     <= 1'b0;
                  Err_code     <= ERR_NONE;
                  Err_idx      <= '0;
               end
            end
            S_FETCH: begin
               wd_cnt <= WD_LOAD;
               case (tbl_op[idx])
                  OP_END: begin
                     state        <= S_DONE;
                     Busy         <= 1'b0;
                     CPU_init_end <= 1'b1;
                  end
                  OP_WRITE: begin
                     state         <= S_WR;
                     S_AXI_awaddr  <= tbl_addr[idx];
                     S_AXI_wdata   <= tbl_data[idx];
                     S_AXI_awvalid <= 1'b1;
                     S_AXI_wvalid  <= 1'b1;
                     aw_done       <= 1'b0;
                     w_done        <= 1'b0;
                  end
                  default: begin
                     state         <= S_RD;
                     S_AXI_araddr  <= tbl_addr[idx];
                     S_AXI_arvalid <= 1'b1;
                  end
               endcase
            end
            S_WR: begin
               if (S_AXI_awvalid && S_AXI_awready) begin
                  S_AXI_awvalid <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (S_AXI_wvalid && S_AXI_wready) begin
                  S_AXI_wvalid <= 1'b0;
                  w_done       <= 1'b1;
               end
               if (aw_ok && w_ok) begin
                  state        <= S_WR_RESP;
                  S_AXI_bready <= 1'b1;
                  wd_cnt       <= WD_LOAD;
               end else begin
                  wd_cnt <= wd_cnt - WW'(1);
               end
            end
            S_WR_RESP: begin
               if (S_AXI_bvalid) begin
                  S_AXI_bready <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt - WW'(1);
               end
            end
            S_RD: begin
               if (S_AXI_arready) begin
                  state         <= S_RD_DATA;
                  S_AXI_arvalid <= 1'b0;
                  S_AXI_rready  <= 1'b1;
                  wd_cnt        <= WD_LOAD;
               end else begin
                  wd_cnt <= wd_cnt - WW'(1);
               end
            end
            S_RD_DATA: begin
               if (S_AXI_rvalid) begin
                  state        <= S_CHECK;
                  S_AXI_rready <= 1'b0;
                  rdata_q      <= S_AXI_rdata;
               end else begin
                  wd_cnt <= wd_cnt - WW'(1);
               end
            end
            S_CHECK: begin
               // Retry path for POLL; a data error below overrides it when the budget is spent.
               if (!match) begin
                  state         <= S_RD;
                  poll_cnt      <= poll_nxt;
                  S_AXI_arvalid <= 1'b1;
                  wd_cnt        <= WD_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (adv) begin
            if (idx == IDX_LAST) begin
               state        <= S_DONE;
               Busy         <= 1'b0;
               CPU_init_end <= 1'b1;
            end else begin
               state    <= S_FETCH;
               idx      <= idx + IW'(1);
               poll_cnt <= '0;
            end
         end

         if (err_req) begin
            state         <= S_ERROR;
            Busy          <= 1'b0;
            Init_err      <= 1'b1;
            Err_code      <= err_code_nxt;
            Err_idx       <= idx;
            S_AXI_awvalid <= 1'b0;
            S_AXI_wvalid  <= 1'b0;
            S_AXI_bready  <= 1'b0;
            S_AXI_arvalid <= 1'b0;
            S_AXI_rready  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_init_seq.sv
// Directed bench for axi_lite_init_seq with a small AXI-Lite slave responder.
module tb_axi_lite_init_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_idx = '0;
   logic [1:0]  cfg_op = '0;
   logic [31:0] cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic [31:0] cfg_mask = '0;
   logic [31:0] awaddr, wdata, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = '0;
   logic        busy, init_end, init_err;
   logic [1:0]  err_code;
   logic [3:0]  err_idx;

   int total = 0;
   int bad = 0;

   // slave configuration (written only by the stimulus block)
   int          sl_dly = 0;
   bit          aw_en = 1'b1;
   logic [1:0]  sl_bresp = 2'b00;
   logic [1:0]  sl_rresp = 2'b00;
   logic [31:0] rd_seq [8];
   int          rd_base = 0;

   // slave bookkeeping (written only by the slave block)
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
   logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;

   always #5 clk = ~clk;

   axi_lite_init_seq dut (
      .Clk_reg(clk), .Reset(rst), .Start(start),
      .Cfg_we(cfg_we), .Cfg_idx(cfg_idx), .Cfg_op(cfg_op),
      .Cfg_addr(cfg_addr), .Cfg_data(cfg_data), .Cfg_mask(cfg_mask),
      .S_AXI_awaddr(awaddr), .S_AXI_awvalid(awvalid), .S_AXI_wdata(wdata),
      .S_AXI_wvalid(wvalid), .S_AXI_bready(bready), .S_AXI_araddr(araddr),
      .S_AXI_arvalid(arvalid), .S_AXI_rready(rready),
      .S_AXI_awready(awready), .S_AXI_wready(wready), .S_AXI_bvalid(bvalid),
      .S_AXI_bresp(bresp), .S_AXI_arready(arready), .S_AXI_rvalid(rvalid),
      .S_AXI_rdata(rdata), .S_AXI_rresp(rresp),
      .Busy(busy), .CPU_init_end(init_end), .Init_err(init_err),
      .Err_code(err_code), .Err_idx(err_idx)
   );

   // Slave responder: decides ready/valid on the falling edge, so a handshake
   // set up here completes on the next rising edge and is logged now.
   always @(negedge clk) begin
      if (awvalid && aw_en) begin
         if (aw_cnt >= sl_dly) begin
            awready = 1'b1; aw_hs++; last_awaddr = awaddr; aw_cnt = 0;
         end else begin
            awready = 1'b0; aw_cnt++;
         end
      end else begin
         awready = 1'b0; aw_cnt = 0;
      end
      if (wvalid) begin
         if (w_cnt >= sl_dly) begin
            wready = 1'b1; w_hs++; last_wdata = wdata; w_cnt = 0;
         end else begin
            wready = 1'b0; w_cnt++;
         end
      end else begin
         wready = 1'b0; w_cnt = 0;
      end
      if (bready) begin
         if (b_cnt >= sl_dly) begin
            bvalid = 1'b1; bresp = sl_bresp; b_hs++; b_cnt = 0;
         end else begin
            bvalid = 1'b0; b_cnt++;
         end
      end else begin
         bvalid = 1'b0; bresp = 2'b00; b_cnt = 0;
      end
      if (arvalid) begin
         if (ar_cnt >= sl_dly) begin
            arready = 1'b1; ar_hs++; last_araddr = araddr; ar_cnt = 0;
         end else begin
            arready = 1'b0; ar_cnt++;
         end
      end else begin
         arready = 1'b0; ar_cnt = 0;
      end
      if (rready) begin
         rvalid = 1'b1;
         rresp  = sl_rresp;
         rdata  = ((r_hs - rd_base) < 8) ? rd_seq[r_hs - rd_base] : rd_seq[7];
         r_hs++;
      end else begin
         rvalid = 1'b0; rresp = 2'b00;
      end
   end

   task automatic cfg(input int i, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] m);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = i[3:0]; cfg_op = op;
      cfg_addr = a; cfg_data = d; cfg_mask = m;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic start_run;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(output int n);
      n = 0;
      while (!(init_end || init_err) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 3000) begin
         bad++; $display("FAIL wait_end timed out after %0d cycles", n);
      end
   endtask

   task automatic test_reset;
      int n;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, init_end, init_err, err_code, err_idx} !== 9'd0) begin
         bad++; $display("FAIL reset_status got=%b exp=0", {busy, init_end, init_err, err_code, err_idx});
      end
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready} !== 5'd0) begin
         bad++; $display("FAIL reset_axi got=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready});
      end
      @(negedge clk);
      rst = 1'b0;
      start_run;
      wait_end(n);
      total++;
      if (n !== 1 || init_end !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL empty_table cycles=%0d end=%b busy=%b exp 1/1/0", n, init_end, busy);
      end
   endtask

   task automatic test_write;
      int n, aw0, w0, b0;
      sl_dly = 2;
      cfg(0, 2'b01, 32'h08, 32'h0000_00A5, 32'h0);
      cfg(1, 2'b00, 32'h0, 32'h0, 32'h0);
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
      start_run;
      wait_end(n);
      total++;
      if (init_end !== 1'b1 || init_err !== 1'b0) begin
         bad++; $display("FAIL write_done end=%b err=%b exp 1/0", init_end, init_err);
      end
      total++;
      if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
         bad++; $display("FAIL write_hs aw=%0d w=%0d b=%0d exp 1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0);
      end
      total++;
      if (last_awaddr !== 32'h08 || last_wdata !== 32'hA5) begin
         bad++; $display("FAIL write_vals addr=%h data=%h exp 08/a5", last_awaddr, last_wdata);
      end
      sl_dly = 0;
   endtask

   task automatic test_read_check;
      int n;
      cfg(0, 2'b10, 32'h10, 32'h1234, 32'hFF00);
      for (int i = 0; i < 8; i++) rd_seq[i] = 32'h12FF;
      rd_base = r_hs;
      start_run;
      wait_end(n);
      total++;
      if (init_end !== 1'b1 || init_err !== 1'b0 || last_araddr !== 32'h10) begin
         bad++; $display("FAIL rdchk_pass end=%b err=%b addr=%h exp 1/0/10", init_end, init_err, last_araddr);
      end
      for (int i = 0; i < 8; i++) rd_seq[i] = 32'h13FF;
      rd_base = r_hs;
      start_run;
      wait_end(n);
      total++;
      if (init_err !== 1'b1 || err_code !== 2'b10 || err_idx !== 4'd0 || init_end !== 1'b0) begin
         bad++; $display("FAIL rdchk_fail err=%b code=%b idx=%0d end=%b exp 1/10/0/0", init_err, err_code, err_idx, init_end);
      end
   endtask

   task automatic test_poll;
      int n, ar0;
      cfg(0, 2'b11, 32'h40, 32'h1, 32'h1);
      for (int i = 0; i < 8; i++) rd_seq[i] = (i >= 3) ? 32'h1 : 32'h0;
      rd_base = r_hs; ar0 = ar_hs;
      start_run;
      wait_end(n);
      total++;
      if (init_end !== 1'b1 || ar_hs - ar0 != 4) begin
         bad++; $display("FAIL poll_pass end=%b reads=%0d exp 1/4", init_end, ar_hs - ar0);
      end
      for (int i = 0; i < 8; i++) rd_seq[i] = 32'h0;
      rd_base = r_hs; ar0 = ar_hs;
      start_run;
      wait_end(n);
      total++;
      if (init_err !== 1'b1 || err_code !== 2'b10 || ar_hs - ar0 != 64) begin
         bad++; $display("FAIL poll_limit err=%b code=%b reads=%0d exp 1/10/64", init_err, err_code, ar_hs - ar0);
      end
   endtask

   task automatic test_errors;
      int n;
      cfg(0, 2'b01, 32'h20, 32'h55, 32'h0);
      cfg(1, 2'b00, 32'h0, 32'h0, 32'h0);
      aw_en = 1'b0;
      start_run;
      wait_end(n);
      total++;
      if (n !== 256) begin
         bad++; $display("FAIL timeout_cycles got=%0d exp=256", n);
      end
      total++;
      if (init_err !== 1'b1 || err_code !== 2'b11 || err_idx !== 4'd0) begin
         bad++; $display("FAIL timeout_code err=%b code=%b idx=%0d exp 1/11/0", init_err, err_code, err_idx);
      end
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready} !== 5'd0) begin
         bad++; $display("FAIL timeout_valids got=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready});
      end
      aw_en = 1'b1;
      sl_bresp = 2'b10;
      start_run;
      wait_end(n);
      total++;
      if (init_err !== 1'b1 || err_code !== 2'b01 || err_idx !== 4'd0) begin
         bad++; $display("FAIL bresp_err err=%b code=%b idx=%0d exp 1/01/0", init_err, err_code, err_idx);
      end
      sl_bresp = 2'b00;
      cfg(1, 2'b10, 32'h24, 32'h0, 32'hFFFF_FFFF);
      cfg(2, 2'b00, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 8; i++) rd_seq[i] = 32'h0;
      rd_base = r_hs;
      sl_rresp = 2'b10;
      start_run;
      wait_end(n);
      total++;
      if (init_err !== 1'b1 || err_code !== 2'b01 || err_idx !== 4'd1) begin
         bad++; $display("FAIL rresp_err err=%b code=%b idx=%0d exp 1/01/1", init_err, err_code, err_idx);
      end
      sl_rresp = 2'b00;
   endtask

   task automatic test_full_table;
      int n, aw0;
      for (int i = 0; i < 16; i++) cfg(i, 2'b01, 32'(i * 4), 32'(i), 32'h0);
      aw0 = aw_hs;
      start_run;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL full_busy got=%b exp=1", busy);
      end
      start = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd5; cfg_op = 2'b00;
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      wait_end(n);
      total++;
      if (init_end !== 1'b1 || init_err !== 1'b0 || aw_hs - aw0 != 16) begin
         bad++; $display("FAIL full_run end=%b err=%b writes=%0d exp 1/0/16", init_end, init_err, aw_hs - aw0);
      end
      total++;
      if (last_awaddr !== 32'h3C || last_wdata !== 32'hF) begin
         bad++; $display("FAIL full_last addr=%h data=%h exp 3c/f", last_awaddr, last_wdata);
      end
   endtask

   task automatic test_reset_mid;
      int n, aw0;
      aw_en = 1'b0;
      start_run;
      n = 0;
      while (!awvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (awvalid !== 1'b1) begin
         bad++; $display("FAIL mid_awvalid got=%b exp=1", awvalid);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({awvalid, wvalid, bready, busy, init_end, init_err} !== 6'd0) begin
         bad++; $display("FAIL mid_reset got=%b exp=000000", {awvalid, wvalid, bready, busy, init_end, init_err});
      end
      @(negedge clk);
      rst = 1'b0;
      aw_en = 1'b1;
      aw0 = aw_hs;
      start_run;
      wait_end(n);
      total++;
      if (init_end !== 1'b1 || n !== 1 || aw_hs - aw0 != 0) begin
         bad++; $display("FAIL mid_table end=%b cycles=%0d writes=%0d exp 1/1/0", init_end, n, aw_hs - aw0);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rd_seq[i] = 32'h0;
      test_reset;
      test_write;
      test_read_check;
      test_poll;
      test_errors;
      test_full_table;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
